// File: rtl/ysyx_22040127_writeback.sv
// Writeback stage: retires one instruction per cycle from the memory stage,
// drives the register-file write port and owns the machine-mode CSRs
// (mstatus, mtvec, mepc, mcause). Handles Zicsr read-modify-write, ecall
// trap entry and mret return, and raises a one-cycle PC redirect.
// Optional build macro WB_PERF_CNT_EN adds the mcycle/minstret counters.
module ysyx_22040127_writeback #(
    parameter int          MEM_TO_WB_WIDTH = 192,
    parameter logic [63:0] MSTATUS_RST     = 64'h0000_000A_0000_1800
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_to_wb_valid,
    output logic                       wb_allowin,
    input  logic [MEM_TO_WB_WIDTH-1:0] mem_to_wb_bus,
    output logic                       rf_we,
    output logic [4:0]                 rf_waddr,
    output logic [63:0]                rf_wdata,
    output logic                       wb_redirect_valid,
    output logic [63:0]                wb_redirect_pc,
    output logic                       retire_valid,
    output logic [31:0]                retire_pc
);

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
`ifdef WB_PERF_CNT_EN
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
`endif

    logic                       wb_valid_q;
    logic [MEM_TO_WB_WIDTH-1:0] bus_q;
    logic                       wb_ready_go;

    logic [63:0] mstatus_q, mstatus_d;
    logic [63:0] mtvec_q,   mtvec_d;
    logic [63:0] mepc_q,    mepc_d;
    logic [63:0] mcause_q,  mcause_d;
`ifdef WB_PERF_CNT_EN
    logic [63:0] mcycle_q,   mcycle_d;
    logic [63:0] minstret_q, minstret_d;
`endif

    logic [11:0] des_csr;
    logic [63:0] alu_input1;
    logic [4:0]  rs1;
    logic        csr_we, mret, ecall;
    logic        csrrw, csrrs, csrrc, csrrwi, csrrsi, csrrci;
    logic [31:0] pc;
    logic        reg_wen;
    logic [4:0]  rd;
    logic [63:0] reg_wdata;

    logic        is_csr;
    logic [63:0] csr_src;
    logic [63:0] csr_old;
    logic [63:0] csr_new;
    logic        csr_wr;

    assign {des_csr, alu_input1, rs1, csr_we, mret, ecall,
            csrrw, csrrs, csrrc, csrrwi, csrrsi, csrrci,
            pc, reg_wen, rd, reg_wdata} = bus_q;

    assign wb_ready_go = 1'b1;
    assign wb_allowin  = !wb_valid_q || wb_ready_go;

    // Stage register: accept a new instruction whenever the stage can take one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_valid_q <= 1'b0;
            bus_q      <= '0;
        end else if (wb_allowin) begin
            wb_valid_q <= mem_to_wb_valid;
            if (mem_to_wb_valid) begin
                bus_q <= mem_to_wb_bus;
            end
        end
    end

    assign is_csr  = csrrw | csrrs | csrrc | csrrwi | csrrsi | csrrci;
    assign csr_src = (csrrwi | csrrsi | csrrci) ? {59'd0, rs1} : alu_input1;
    // ecall and mret outrank a CSR op carried on the same instruction.
    assign csr_wr  = wb_valid_q & csr_we & is_csr & ~ecall & ~mret;

    // CSR read mux; unimplemented addresses read as zero.
    always_comb begin
        csr_old = 64'd0;
        case (des_csr)
            CSR_MSTATUS:  csr_old = mstatus_q;
            CSR_MTVEC:    csr_old = mtvec_q;
            CSR_MEPC:     csr_old = mepc_q;
            CSR_MCAUSE:   csr_old = mcause_q;
`ifdef WB_PERF_CNT_EN
            CSR_MCYCLE:   csr_old = mcycle_q;
            CSR_MINSTRET: csr_old = minstret_q;
`endif
            default:      csr_old = 64'd0;
        endcase
    end

    // Read-modify-write value for the Zicsr ops.
    always_comb begin
        csr_new = csr_old & ~csr_src;
        if (csrrw | csrrwi) begin
            csr_new = csr_src;
        end else if (csrrs | csrrsi) begin
            csr_new = csr_old | csr_src;
        end
    end

    // CSR next-state: trap entry, trap return, then software writes.
    always_comb begin
        mstatus_d  = mstatus_q;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
`ifdef WB_PERF_CNT_EN
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, wb_valid_q};
`endif
        if (wb_valid_q && ecall) begin
            mepc_d       = {32'd0, pc};
            mcause_d     = 64'd11;
            mstatus_d[7] = mstatus_q[3];
            mstatus_d[3] = 1'b0;
        end else if (wb_valid_q && mret) begin
            mstatus_d[3] = mstatus_q[7];
            mstatus_d[7] = 1'b1;
        end else if (csr_wr) begin
            case (des_csr)
                CSR_MSTATUS:  mstatus_d  = csr_new;
                CSR_MTVEC:    mtvec_d    = csr_new;
                CSR_MEPC:     mepc_d     = csr_new;
                CSR_MCAUSE:   mcause_d   = csr_new;
`ifdef WB_PERF_CNT_EN
                CSR_MCYCLE:   mcycle_d   = csr_new;
                CSR_MINSTRET: minstret_d = csr_new;
`endif
                default: ;
            endcase
        end
    end

    // CSR state registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mstatus_q  <= MSTATUS_RST;
            mtvec_q    <= 64'd0;
            mepc_q     <= 64'd0;
            mcause_q   <= 64'd0;
`ifdef WB_PERF_CNT_EN
            mcycle_q   <= 64'd0;
            minstret_q <= 64'd0;
`endif
        end else begin
            mstatus_q  <= mstatus_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
`ifdef WB_PERF_CNT_EN
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
`endif
        end
    end

    assign rf_we             = wb_valid_q & reg_wen & (rd != 5'd0);
    assign rf_waddr          = wb_valid_q ? rd : 5'd0;
    assign rf_wdata          = wb_valid_q ? (is_csr ? csr_old : reg_wdata) : 64'd0;
    assign wb_redirect_valid = wb_valid_q & (ecall | mret);
    assign wb_redirect_pc    = !wb_redirect_valid ? 64'd0 :
                               ecall ? {mtvec_q[63:2], 2'b00} : mepc_q;
    assign retire_valid      = wb_valid_q;
    assign retire_pc         = wb_valid_q ? pc : 32'd0;

endmodule

// File: doc/ysyx_22040127_writeback.md
Name: ysyx_22040127_writeback

Overview:
Final (WB) pipeline stage, directly downstream of the memory stage; consumes its 192-bit mem-to-wb bus through the valid/allowin handshake. Retires one instruction per cycle: drives the integer register-file write port and owns the machine-mode CSR file (mstatus, mtvec, mepc, mcause). Executes Zicsr read-modify-write, ecall trap entry and mret return, and issues a one-cycle PC redirect to the front end.

Parameters:
MEM_TO_WB_WIDTH, 192, width of input bus.
MSTATUS_RST, 64'h0000_000A_0000_1800, mstatus reset value (UXL/SXL=2, MPP=3).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-low reset (0 = reset).
mem_to_wb_valid  input  1  upstream instruction valid.
wb_allowin  output  1  stage can accept an instruction.
mem_to_wb_bus  input  192  {des_csr[191:180], alu_input1[179:116], rs1[115:111], csr_we[110], mret[109], ecall[108], csrrw[107], csrrs[106], csrrc[105], csrrwi[104], csrrsi[103], csrrci[102], pc[101:70], reg_wen[69], rd[68:64], reg_wdata[63:0]}.
rf_we  output  1  register-file write enable.
rf_waddr  output  5  destination register.
rf_wdata  output  64  write data.
wb_redirect_valid  output  1  redirect pulse (ecall/mret retiring).
wb_redirect_pc  output  64  redirect target.
retire_valid  output  1  instruction retires this cycle.
retire_pc  output  32  PC of retiring instruction.

Behaviour:
- Handshake: wb_ready_go=1; wb_allowin = !wb_valid | wb_ready_go (always 1 in this revision, kept for uniformity). On edge with wb_allowin: wb_valid <= mem_to_wb_valid; bus register loaded only when mem_to_wb_valid & wb_allowin.
- Reset (rst=0 at edge): wb_valid<=0, bus register<=0, mstatus<=MSTATUS_RST, mtvec/mepc/mcause<=0. All outputs then 0 (gated by wb_valid). Reset mid-instruction discards it; no CSR or RF side effect.
- Latency: 1 cycle from accept to retire; all outputs combinational from the stage register, RF/CSR updates at the next edge.
- is_csr = csrrw|csrrs|csrrc|csrrwi|csrrsi|csrrci. src = imm-form ? zero-extended rs1 (5b) : alu_input1.
- CSR read: old = mux on des_csr {0x300,0x305,0x341,0x342}; unimplemented address reads 0.
- CSR new value: rw: src; rs: old|src; rc: old&~src. Write performed only if wb_valid & csr_we & address implemented; unimplemented writes ignored. rs/rc with src=0 still write (no side effects exist).
- RF: rf_we = wb_valid & reg_wen & (rd!=0). rf_wdata = is_csr ? old : reg_wdata. rf_waddr = rd.
- ecall (wb_valid): mepc<=zero-extended pc, mcause<=11, mstatus.MPIE(bit7)<=MIE(bit3), MIE<=0; wb_redirect_valid=1, wb_redirect_pc=mtvec with bits[1:0] forced 0.
- mret (wb_valid): MIE<=MPIE, MPIE<=1; redirect to mepc.
- Priority if several flags set: ecall > mret > csr op; lower-priority effects suppressed.
- retire_valid = wb_valid; retire_pc = pc. Redirect lasts exactly the cycle the instruction sits in WB.

Optional Feature:
WB_PERF_CNT_EN: defined -> adds 64-bit mcycle (0xB00, +1 every non-reset cycle) and minstret (0xB02, +1 per retire_valid); both CSR-readable/writable, write takes precedence over increment that cycle; reset to 0. Undefined -> addresses unimplemented (read 0, writes ignored), no counter flops.

Test Plan:
- Reset: hold rst=0 2 cycles with valid=1 -> rf_we=0, wb_redirect_valid=0; csrr mstatus afterwards returns 0x0000000A00001800.
- ALU write: valid, reg_wen=1, rd=5, reg_wdata=0x1234 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234; same with rd=0 -> rf_we=0.
- csrrw mtvec: src=0x80001000, rd=6 -> rf_wdata=0 (old); subsequent csrrs rs1=0 on 0x305 -> rf_wdata=0x80001000.
- csrrci mstatus imm=8 from reset -> rf_wdata=0xA00001800, mstatus bit3 stays 0; csrrsi imm=8 then csrrci imm=8 -> bit3 set then cleared.
- ecall pc=0x80000010, mtvec=0x80001003, MIE=1 -> redirect_pc=0x80001000, mepc=0x80000010, mcause=11, MIE=0, MPIE=1; mret -> redirect_pc=0x80000010, MIE=1.
- Back-to-back valid every cycle for 10 instructions -> 10 retire pulses, no bubbles; with WB_PERF_CNT_EN minstret=10.
